// File: rtl/syn_tle_drain.sv
// Tile drain for the matmul engine: buffers one MxN result tile and streams it
// downstream one row per beat, optionally saturating each element to OUTW bits.
//
// state   | meaning
// EMPTY   | no tile held; ready_o=1, valid_o=0
// DRAIN   | tile held; row rcnt presented on row_o with valid_o=1
module syn_tle_drain #(
  parameter int M    = 2,
  parameter int N    = 2,
  parameter int P    = 8,
  parameter int OUTW = 4*P,
  parameter int RW   = (M > 1) ? $clog2(M) : 1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic signed [4*P-1:0]  D_i [M][N],
  input  logic                   valid_i,
  output logic                   ready_o,
  output logic signed [OUTW-1:0] row_o [N],
  output logic [N-1:0]           sat_o,
  output logic [RW-1:0]          row_idx_o,
  output logic                   last_o,
  output logic                   valid_o,
  input  logic                   ready_i
);

  localparam int IW = 4*P;

  localparam logic [0:0] S_EMPTY = 1'b0;
  localparam logic [0:0] S_DRAIN = 1'b1;

  logic [0:0]           state_q, state_d;
  logic [RW-1:0]        rcnt_q, rcnt_d;
  logic signed [IW-1:0] buf_q [M][N];
  logic signed [IW-1:0] cur [N];
  logic                 acc, beat, last;

  assign last      = (rcnt_q == RW'(M-1));
  assign valid_o   = (state_q == S_DRAIN);
  assign beat      = valid_o && ready_i;
  // A new tile may land in the same edge that retires the last row.
  assign ready_o   = rst_ni && ((state_q == S_EMPTY) || (beat && last));
  assign acc       = valid_i && ready_o;
  assign row_idx_o = rcnt_q;
  assign last_o    = last;

  always_comb begin
    state_d = state_q;
    rcnt_d  = rcnt_q;
    if (acc) begin
      state_d = S_DRAIN;
      rcnt_d  = '0;
    end else if (beat) begin
      if (last) state_d = S_EMPTY;
      else      rcnt_d  = rcnt_q + RW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= S_EMPTY;
      rcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      rcnt_q  <= rcnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (acc) buf_q <= D_i;
  end

  always_comb begin
    cur = buf_q[0];
    for (int r = 1; r < M; r++) begin
      if (rcnt_q == RW'(r)) cur = buf_q[r];
    end
  end

  for (genvar j = 0; j < N; j++) begin : g_conv
    if (OUTW == IW) begin : g_pass
      assign row_o[j] = cur[j];
      assign sat_o[j] = 1'b0;
    end else begin : g_sat
      localparam logic signed [IW-1:0] MAXV = {{(IW-OUTW+1){1'b0}}, {(OUTW-1){1'b1}}};
      localparam logic signed [IW-1:0] MINV = {{(IW-OUTW+1){1'b1}}, {(OUTW-1){1'b0}}};
      logic hi, lo;
      assign hi       = cur[j] > MAXV;
      assign lo       = cur[j] < MINV;
      assign row_o[j] = hi ? MAXV[OUTW-1:0] : (lo ? MINV[OUTW-1:0] : cur[j][OUTW-1:0]);
      assign sat_o[j] = hi || lo;
    end
  end

endmodule

// File: tb/tb_syn_tle_drain.sv
// Scoreboard bench for syn_tle_drain: three instances (default, OUTW=8, M=1);
// expected beats are queued at stimulus time and popped by per-instance monitors.
module tb_syn_tle_drain;

  typedef struct {
    int         e0;
    int         e1;
    logic [1:0] sat;
    int         idx;
    logic       last;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  beat_t q0[$], q1[$], q2[$];

  // instance 0: M=N=2, P=8, pass-through
  logic signed [31:0] d0 [2][2];
  logic signed [31:0] row0 [2];
  logic [1:0] sat0;
  logic [0:0] idx0;
  logic vi0, ro0, last0, vo0, ri0;
  syn_tle_drain #(.M(2), .N(2), .P(8)) u0 (
    .clk_i(clk), .rst_ni(rst_n), .D_i(d0), .valid_i(vi0), .ready_o(ro0),
    .row_o(row0), .sat_o(sat0), .row_idx_o(idx0), .last_o(last0),
    .valid_o(vo0), .ready_i(ri0));

  // instance 1: saturating to 8 bits
  logic signed [31:0] d1 [2][2];
  logic signed [7:0] row1 [2];
  logic [1:0] sat1;
  logic [0:0] idx1;
  logic vi1, ro1, last1, vo1, ri1;
  syn_tle_drain #(.M(2), .N(2), .P(8), .OUTW(8)) u1 (
    .clk_i(clk), .rst_ni(rst_n), .D_i(d1), .valid_i(vi1), .ready_o(ro1),
    .row_o(row1), .sat_o(sat1), .row_idx_o(idx1), .last_o(last1),
    .valid_o(vo1), .ready_i(ri1));

  // instance 2: single-row tile
  logic signed [31:0] d2 [1][2];
  logic signed [31:0] row2 [2];
  logic [1:0] sat2;
  logic [0:0] idx2;
  logic vi2, ro2, last2, vo2, ri2;
  syn_tle_drain #(.M(1), .N(2), .P(8)) u2 (
    .clk_i(clk), .rst_ni(rst_n), .D_i(d2), .valid_i(vi2), .ready_o(ro2),
    .row_o(row2), .sat_o(sat2), .row_idx_o(idx2), .last_o(last2),
    .valid_o(vo2), .ready_i(ri2));

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic beat_t mk(input int a, input int b, input logic [1:0] s,
                               input int i, input logic l);
    beat_t t;
    t.e0 = a; t.e1 = b; t.sat = s; t.idx = i; t.last = l;
    return t;
  endfunction

  task automatic cmp_beat(input string tag, input int a0, input int a1,
                          input logic [1:0] s, input int i, input logic l,
                          input beat_t e);
    check({tag, " row[0]"}, a0, e.e0);
    check({tag, " row[1]"}, a1, e.e1);
    check({tag, " sat"}, int'(s), int'(e.sat));
    check({tag, " row_idx"}, i, e.idx);
    check({tag, " last"}, int'(l), int'(e.last));
  endtask

  task automatic no_beat(input string tag);
    n_cmp++;
    n_bad++;
    $display("FAIL %s unexpected beat: got a beat expected none", tag);
  endtask

  always @(negedge clk) begin
    if (vo0 === 1'b1 && ri0 === 1'b1) begin
      if (q0.size() == 0) no_beat("u0");
      else cmp_beat("u0", int'(row0[0]), int'(row0[1]), sat0, int'(idx0), last0, q0.pop_front());
    end
    if (vo1 === 1'b1 && ri1 === 1'b1) begin
      if (q1.size() == 0) no_beat("u1");
      else cmp_beat("u1", int'(row1[0]), int'(row1[1]), sat1, int'(idx1), last1, q1.pop_front());
    end
    if (vo2 === 1'b1 && ri2 === 1'b1) begin
      if (q2.size() == 0) no_beat("u2");
      else cmp_beat("u2", int'(row2[0]), int'(row2[1]), sat2, int'(idx2), last2, q2.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill0(input int v);
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 2; c++) d0[r][c] = v;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    vi0 = 0; vi1 = 0; vi2 = 0;
    ri0 = 1; ri1 = 1; ri2 = 1;
    fill0(0);
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 2; c++) d1[r][c] = 0;
    d2[0][0] = 0; d2[0][1] = 0;

    tick();
    check("ready_o low in reset", int'(ro0), 0);
    tick();
    rst_n = 1'b1;
    #1;
    check("reset valid_o", int'(vo0), 0);
    check("reset ready_o", int'(ro0), 1);
    check("reset row_idx", int'(idx0), 0);

    // single tile of 7s
    fill0(7);
    vi0 = 1;
    q0.push_back(mk(7, 7, 2'b00, 0, 1'b0));
    q0.push_back(mk(7, 7, 2'b00, 1, 1'b1));
    tick();
    vi0 = 0;
    check("single ready_o after accept", int'(ro0), 0);
    check("single valid_o row0", int'(vo0), 1);
    tick();
    check("single ready_o on last beat", int'(ro0), 1);
    tick();
    check("single valid_o empty", int'(vo0), 0);
    check("single ready_o empty", int'(ro0), 1);

    // backpressure on row 0 for 5 cycles
    ri0 = 0;
    vi0 = 1;
    q0.push_back(mk(7, 7, 2'b00, 0, 1'b0));
    q0.push_back(mk(7, 7, 2'b00, 1, 1'b1));
    tick();
    vi0 = 0;
    fill0(99);
    for (int i = 0; i < 5; i++) begin
      check("bp valid_o", int'(vo0), 1);
      check("bp row[0]", int'(row0[0]), 7);
      check("bp row[1]", int'(row0[1]), 7);
      check("bp row_idx", int'(idx0), 0);
      check("bp last", int'(last0), 0);
      check("bp ready_o", int'(ro0), 0);
      if (i < 4) tick();
    end
    ri0 = 1;
    tick();
    check("bp row1 valid_o", int'(vo0), 1);
    check("bp row1 row_idx", int'(idx0), 1);
    tick();
    check("bp done valid_o", int'(vo0), 0);

    // back-to-back tiles
    fill0(7);
    vi0 = 1;
    q0.push_back(mk(7, 7, 2'b00, 0, 1'b0));
    q0.push_back(mk(7, 7, 2'b00, 1, 1'b1));
    q0.push_back(mk(1, 2, 2'b00, 0, 1'b0));
    q0.push_back(mk(3, 4, 2'b00, 1, 1'b1));
    tick();
    d0[0][0] = 1; d0[0][1] = 2; d0[1][0] = 3; d0[1][1] = 4;
    check("b2b ready_o row0", int'(ro0), 0);
    check("b2b valid_o beat0", int'(vo0), 1);
    tick();
    check("b2b ready_o pulse", int'(ro0), 1);
    check("b2b valid_o beat1", int'(vo0), 1);
    tick();
    vi0 = 0;
    check("b2b valid_o beat2", int'(vo0), 1);
    check("b2b row_idx beat2", int'(idx0), 0);
    tick();
    check("b2b valid_o beat3", int'(vo0), 1);
    tick();
    check("b2b valid_o end", int'(vo0), 0);

    // reset while row 0 is held
    ri0 = 0;
    fill0(7);
    vi0 = 1;
    tick();
    vi0 = 0;
    check("rst-mid valid_o before", int'(vo0), 1);
    rst_n = 1'b0;
    #1;
    check("rst-mid ready_o in reset", int'(ro0), 0);
    tick();
    rst_n = 1'b1;
    #1;
    check("rst-mid valid_o after", int'(vo0), 0);
    check("rst-mid ready_o after", int'(ro0), 1);
    ri0 = 1;
    tick();
    check("rst-mid no beat", int'(vo0), 0);
    fill0(5);
    vi0 = 1;
    q0.push_back(mk(5, 5, 2'b00, 0, 1'b0));
    q0.push_back(mk(5, 5, 2'b00, 1, 1'b1));
    tick();
    vi0 = 0;
    tick();
    tick();
    check("rst-mid drained", int'(vo0), 0);

    // saturation to 8 bits
    d1[0][0] = 300; d1[0][1] = -200; d1[1][0] = 127; d1[1][1] = -128;
    vi1 = 1;
    q1.push_back(mk(127, -128, 2'b11, 0, 1'b0));
    q1.push_back(mk(127, -128, 2'b00, 1, 1'b1));
    tick();
    d1[0][0] = 128; d1[0][1] = -129; d1[1][0] = -1; d1[1][1] = 5;
    q1.push_back(mk(127, -128, 2'b11, 0, 1'b0));
    q1.push_back(mk(-1, 5, 2'b00, 1, 1'b1));
    tick();
    tick();
    vi1 = 0;
    tick();
    tick();
    check("sat drained", int'(vo1), 0);

    // single-row tile
    d2[0][0] = 9; d2[0][1] = -9;
    vi2 = 1;
    q2.push_back(mk(9, -9, 2'b00, 0, 1'b1));
    tick();
    vi2 = 0;
    check("m1 valid_o", int'(vo2), 1);
    check("m1 last", int'(last2), 1);
    check("m1 ready_o", int'(ro2), 1);
    tick();
    check("m1 valid_o empty", int'(vo2), 0);
    check("m1 ready_o empty", int'(ro2), 1);

    tick();
    check("u0 beats outstanding", q0.size(), 0);
    check("u1 beats outstanding", q1.size(), 0);
    check("u2 beats outstanding", q2.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
